// File: rtl/dataplane_pkg.sv
// Shared types and constants for the packet dataplane blocks
// (flow_key_gen -> flow_table).
package dataplane_pkg;

  localparam int FLOW_KEY_W = 96;
  localparam int FLOW_CNT_W = 32;

  // One logical table entry as seen by software.
  typedef struct packed {
    logic                  valid;
    logic [FLOW_KEY_W-1:0] key;
    logic [FLOW_CNT_W-1:0] pkt_cnt;
    logic [FLOW_CNT_W-1:0] byte_cnt;
  } flow_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    UPDATE = 2'd2,
    CLEAR  = 2'd3
  } ft_state_e;

  // CSR read selectors
  localparam logic [1:0] RD_SEL_PKT   = 2'd0;
  localparam logic [1:0] RD_SEL_BYTE  = 2'd1;
  localparam logic [1:0] RD_SEL_VALID = 2'd2;
  localparam logic [1:0] RD_SEL_KEY   = 2'd3;

endpackage

// File: rtl/flow_hash.sv
// Combinational XOR-fold hash: the key is zero-extended to a whole number of
// IDX_W slices and all slices are XORed together to form the table index.
module flow_hash #(
  parameter int KEY_W = 96,
  parameter int IDX_W = 4
) (
  input  logic [KEY_W-1:0] i_key,
  output logic [IDX_W-1:0] o_idx
);

  localparam int NSLICE = (KEY_W + IDX_W - 1) / IDX_W;
  localparam int PAD_W  = NSLICE * IDX_W;

  logic [PAD_W-1:0] w_pad;

  assign w_pad = PAD_W'(i_key);

  // Fold every IDX_W-wide slice of the padded key into one index.
  always_comb begin
    o_idx = '0;
    for (int s = 0; s < NSLICE; s++) begin
      o_idx = o_idx ^ w_pad[s*IDX_W +: IDX_W];
    end
  end

endmodule

// File: rtl/flow_table.sv
// Direct-mapped per-flow packet/byte statistics table. Each accepted key walks
// IDLE -> LOOKUP -> UPDATE; a clear request empties the table in one CLEAR
// cycle. Counters saturate. A CSR read port runs independently of the FSM.
module flow_table
  import dataplane_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int KEY_W = FLOW_KEY_W,
  parameter  int CNT_W = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] flow_key,
  input  logic [15:0]      pkt_bytes,
  output logic             key_ready,
  input  logic             clr,
  output logic             res_valid,
  output logic             res_hit,
  output logic             res_evict,
  output logic [IDX_W-1:0] res_idx,
  output logic [CNT_W-1:0] evict_cnt,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [1:0]       rd_sel,
  output logic [31:0]      rd_data,
  output logic             rd_done
);

  localparam int SUM_W = ((CNT_W > 16) ? CNT_W : 16) + 1;

  // Saturating increment: an all-ones counter stays all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating add of a zero-extended byte count.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [15:0]      b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(v) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Fit a counter onto the 32-bit CSR bus (truncate or zero-extend).
  function automatic logic [31:0] fit32(input logic [CNT_W-1:0] v);
    logic [CNT_W+31:0] t;
    t = {32'b0, v};
    return t[31:0];
  endfunction

  ft_state_e        r_state;
  logic             r_clr_pend;
  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_evict_cnt;

  logic [KEY_W-1:0] r_key;
  logic [15:0]      r_bytes;
  logic [IDX_W-1:0] r_idx;
  logic             r_hit;
  logic             r_evict;
  logic [CNT_W-1:0] r_old_pkt;
  logic [CNT_W-1:0] r_old_byte;

  logic [KEY_W-1:0] r_key_mem  [DEPTH];
  logic [CNT_W-1:0] r_pkt_mem  [DEPTH];
  logic [CNT_W-1:0] r_byte_mem [DEPTH];

  logic [31:0]      r_rd_data;
  logic             r_rd_done;

  logic [IDX_W-1:0] w_hash_idx;
  logic             w_accept;

  flow_hash #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_hash (
    .i_key (flow_key),
    .o_idx (w_hash_idx)
  );

  // A clear request in IDLE takes priority and discards any offered key.
  assign w_accept = (r_state == IDLE) && key_valid && !clr;

  // Control FSM: state, pending clear, valid bits and eviction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_clr_pend  <= 1'b0;
      r_valid     <= '0;
      r_evict_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr)            r_state <= CLEAR;
          else if (key_valid) r_state <= LOOKUP;
        end
        LOOKUP: begin
          if (clr) r_clr_pend <= 1'b1;
          r_state <= UPDATE;
        end
        UPDATE: begin
          r_valid[r_idx] <= 1'b1;
          if (r_evict) r_evict_cnt <= sat_inc(r_evict_cnt);
          r_state    <= (r_clr_pend || clr) ? CLEAR : IDLE;
          r_clr_pend <= 1'b0;
        end
        CLEAR: begin
          r_valid     <= '0;
          r_evict_cnt <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath: capture the key on accept, snapshot the entry during LOOKUP.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_key   <= flow_key;
      r_bytes <= pkt_bytes;
      r_idx   <= w_hash_idx;
    end
    if (r_state == LOOKUP) begin
      r_hit      <= r_valid[r_idx] && (r_key_mem[r_idx] == r_key);
      r_evict    <= r_valid[r_idx] && (r_key_mem[r_idx] != r_key);
      r_old_pkt  <= r_pkt_mem[r_idx];
      r_old_byte <= r_byte_mem[r_idx];
    end
  end

  // Table storage write in UPDATE: accumulate on hit, install otherwise.
  always_ff @(posedge clk) begin
    if (r_state == UPDATE) begin
      if (r_hit) begin
        r_pkt_mem[r_idx]  <= sat_inc(r_old_pkt);
        r_byte_mem[r_idx] <= sat_add(r_old_byte, r_bytes);
      end else begin
        r_key_mem[r_idx]  <= r_key;
        r_pkt_mem[r_idx]  <= CNT_W'(1);
        r_byte_mem[r_idx] <= sat_add('0, r_bytes);
      end
    end
  end

  // CSR read port: samples storage before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_done <= 1'b0;
    end else begin
      r_rd_done <= rd_en;
      if (rd_en) begin
        case (rd_sel)
          RD_SEL_PKT:   r_rd_data <= fit32(r_pkt_mem[rd_idx]);
          RD_SEL_BYTE:  r_rd_data <= fit32(r_byte_mem[rd_idx]);
          RD_SEL_VALID: r_rd_data <= {31'b0, r_valid[rd_idx] && (r_state != CLEAR)};
          default:      r_rd_data <= r_key_mem[rd_idx][31:0];
        endcase
      end
    end
  end

  assign key_ready = (r_state == IDLE);
  assign res_valid = (r_state == UPDATE);
  assign res_hit   = res_valid && r_hit;
  assign res_evict = res_valid && r_evict;
  assign res_idx   = res_valid ? r_idx : '0;
  assign evict_cnt = r_evict_cnt;
  assign rd_data   = r_rd_data;
  assign rd_done   = r_rd_done;

endmodule
